// File: rtl/word_tx.sv
// word_tx: buffers one word of characters, then streams it out. A 'U'
// is inserted after every 'Q' that is not already followed by one, and
// every word ends with a 0x00 terminator. Words longer than DEPTH are
// truncated. 0x00 input characters are dropped and flagged.
module word_tx #(
   parameter int unsigned DEPTH  = 8,
   parameter logic [7:0]  CHAR_Q = 8'd81,
   parameter logic [7:0]  CHAR_U = 8'd85
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] in_char,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [7:0] out_char,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy,
   output logic       trunc,
   output logic       bad_char
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);

   typedef enum logic [2:0] {LOAD, SEND, INS_U, TERM, DROP} state_t;

   state_t         state;
   logic [7:0]     buffer [DEPTH];
   logic [CW-1:0]  count;
   logic [IW-1:0]  idx;

   logic           in_hs;
   logic           out_hs;
   logic           idx_last;
   logic           q_needs_u;
   logic [IW-1:0]  idx_nxt;
   logic [IW-1:0]  wr_idx;
   logic [7:0]     cur_char;
   logic [7:0]     nxt_char;
   logic [7:0]     first_char;

   assign in_hs    = in_valid && in_ready;
   assign out_hs   = out_valid && out_ready;
   assign idx_last = (CW'(idx) == count - CW'(1));
   assign idx_nxt  = idx + IW'(1);
   // count never exceeds DEPTH-1 while characters are still being stored
   assign wr_idx   = count[IW-1:0];
   assign cur_char = buffer[idx];
   // the successor is only meaningful when idx is not the last entry
   assign nxt_char = idx_last ? cur_char : buffer[idx_nxt];
   assign q_needs_u = (cur_char == CHAR_Q) && (idx_last || (nxt_char != CHAR_U));
   // the first character of a one-char-so-far word is still on in_char
   assign first_char = (count == '0) ? in_char : buffer[0];

   // Character storage: written only while loading, never reset
   always_ff @(posedge clock) begin
      if (state == LOAD && in_hs && in_char != 8'd0) begin
         buffer[wr_idx] <= in_char;
      end
   end

   // Control FSM with registered handshake, data and status outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= LOAD;
         count     <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         out_char  <= 8'd0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         trunc     <= 1'b0;
         bad_char  <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (in_hs) begin
                  if (in_char == 8'd0) begin
                     bad_char <= 1'b1;
                     // a word made only of dropped characters is discarded
                     if (in_last && count != '0) begin
                        state     <= SEND;
                        idx       <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_char  <= buffer[0];
                     end
                  end else begin
                     count <= count + CW'(1);
                     if (in_last) begin
                        state     <= SEND;
                        idx       <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_char  <= first_char;
                     end else if (count == CW'(DEPTH - 1)) begin
                        state <= DROP;
                        busy  <= 1'b1;
                        trunc <= 1'b1;
                     end
                  end
               end
            end
            DROP: begin
               if (in_hs && in_last) begin
                  state     <= SEND;
                  idx       <= '0;
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
                  out_char  <= buffer[0];
               end
            end
            SEND: begin
               if (out_hs) begin
                  if (q_needs_u) begin
                     state    <= INS_U;
                     out_char <= CHAR_U;
                  end else if (idx_last) begin
                     state    <= TERM;
                     out_char <= 8'd0;
                  end else begin
                     idx      <= idx_nxt;
                     out_char <= buffer[idx_nxt];
                  end
               end
            end
            INS_U: begin
               if (out_hs) begin
                  if (idx_last) begin
                     state    <= TERM;
                     out_char <= 8'd0;
                  end else begin
                     state    <= SEND;
                     idx      <= idx_nxt;
                     out_char <= buffer[idx_nxt];
                  end
               end
            end
            TERM: begin
               if (out_hs) begin
                  state     <= LOAD;
                  count     <= '0;
                  idx       <= '0;
                  out_valid <= 1'b0;
                  out_char  <= 8'd0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: doc/word_tx.md
WORD_TX -- requirements
Module: word_tx

Interface
REQ-001 Parameter DEPTH, default 8, is the maximum number of loaded characters held for one word (2..16).
REQ-002 Parameter CHAR_Q, default 8'd81, is the character that requires a following 'U'.
REQ-003 Parameter CHAR_U, default 8'd85, is the character inserted after CHAR_Q.
REQ-004 Port clock, input, 1, rising-edge clock for all state.
REQ-005 Port reset, input, 1, reset, synchronous, active-high.
REQ-006 Port in_char, input, 8, character offered by the host.
REQ-007 Port in_valid, input, 1, in_char is valid this cycle.
REQ-008 Port in_last, input, 1, in_char is the final character of the word; qualified by in_valid.
REQ-009 Port in_ready, output, 1, block accepts in_char this cycle.
REQ-010 Port out_char, output, 8, emitted stream byte; 8'd0 is the word terminator.
REQ-011 Port out_valid, output, 1, out_char is valid this cycle.
REQ-012 Port out_ready, input, 1, downstream consumes out_char this cycle.
REQ-013 Port busy, output, 1, high in any state other than LOAD.
REQ-014 Port trunc, output, 1, sticky flag: a word exceeded DEPTH characters.
REQ-015 Port bad_char, output, 1, sticky flag: a 8'd0 character was offered and dropped.

Function
REQ-016 The input handshake completes on a cycle when in_valid and in_ready are both high; the output handshake completes on a cycle when out_valid and out_ready are both high.
REQ-017 The block SHALL implement states LOAD, SEND, INS_U, TERM and DROP, with all outputs registered.
REQ-018 In LOAD, in_ready is 1; each accepted non-zero char is written to buffer[count] and count increments.
REQ-019 In LOAD, an accepted in_char of 8'd0 is not stored, sets bad_char, and its in_last is still honoured; if count=0 at that point, the word is discarded and the state stays LOAD.
REQ-020 In LOAD, an accepted char with in_last moves the state to SEND on the next cycle, with idx=0.
REQ-021 In LOAD, accepting the DEPTH-th char without in_last moves the state to DROP and sets trunc.
REQ-022 In DROP, in_ready is 1 and accepted chars are discarded; an accepted in_last moves the state to SEND with idx=0.
REQ-023 In SEND, INS_U and TERM, in_ready is 0; in these states busy is 1.
REQ-024 In SEND, out_valid is 1 and out_char is buffer[idx].
REQ-025 In SEND, when the handshake completes, the next state is decided as follows:
  - if buffer[idx]=CHAR_Q and either idx=count-1 or buffer[idx+1]!=CHAR_U, go to INS_U;
  - else, if idx=count-1, go to TERM;
  - otherwise, increment idx.
REQ-026 In INS_U, out_valid is 1 and out_char is CHAR_U; on handshake, go to SEND with idx+1, or to TERM if idx=count-1.
REQ-027 In TERM, out_valid is 1 and out_char is 8'd0; on handshake, clear count and idx and return to LOAD.
REQ-028 While out_valid is 1 and out_ready is 0, out_char, state and idx SHALL hold unchanged.
REQ-029 Whenever out_valid is 0, out_char is 8'd0.
REQ-030 Latency: the first character appears on out_char one cycle after the in_last handshake.
REQ-031 With out_ready held at 1, the block emits one byte per cycle with no bubbles within a word.
REQ-032 The 0x00 terminator is always emitted, including after a truncated word.
REQ-033 A CHAR_U already following CHAR_Q in the buffer is never duplicated.
REQ-034 Consecutive CHAR_Q chars each receive an inserted U ("QQ" -> Q,U,Q,U,0).
REQ-035 count is $clog2(DEPTH+1) bits wide and idx is $clog2(DEPTH) bits wide; neither wraps, because transitions occur at DEPTH and count-1 respectively.

Reset
REQ-036 On a clock edge with reset=1, the block SHALL set:
  - state to LOAD;
  - count and idx to 0;
  - out_valid to 0 and out_char to 8'd0;
  - in_ready to 1;
  - busy, trunc and bad_char to 0.
REQ-037 Reset asserted mid-word, in any state, abandons the word with no terminator emitted; buffer contents are don't-care.
REQ-038 Input handshakes are ignored while reset=1.

Verification
REQ-039 The bench SHALL drive load 81,73(last) with out_ready=1 and check out_char 81,85,73,0 on consecutive cycles, after which in_ready=1.
REQ-040 The bench SHALL drive load 81,85(last) and check out 81,85,0 with no extra U; then drive load 81(last) and check out 81,85,0.
REQ-041 The bench SHALL use DEPTH=4, load 65,66,67,68,69,70(last), and check out 65,66,67,68,0 with trunc=1 held until reset.
REQ-042 The bench SHALL load 66,67(last), hold out_ready=0 for 3 cycles, and check out_char=66 stable with out_valid=1 and busy=1; it SHALL then release out_ready and check 66,67,0.
REQ-043 The bench SHALL load 0,65(last) and check out 65,0 with bad_char=1; it SHALL then load 0(last) alone and check that there is no output and the state is LOAD.
REQ-044 The bench SHALL assert reset during SEND of a 3-char word and, on the next cycle, check out_valid=0, out_char=0, in_ready=1, busy=0, trunc=0 and bad_char=0.
